// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered MIPS decode with valid/ready, load-use scoreboard, flush, sticky halt; perf counters under DECODE_CTRL_PERF_EN
module decode_ctrl_pipe #(
  parameter int WORD_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  output logic              ctrl_valid_o,
  output logic [3:0]        aluop_o,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
  output logic [REG_AW-1:0] wsel_o,
  output logic [WORD_W-1:0] imm_ext_o,
  output logic [25:0]       imm26_o,
  output logic [1:0]        alu_src_o,
  output logic [1:0]        jump_sel_o,
  output logic              branch_o,
  output logic              bne_o,
  output logic              reg_write_o,
  output logic              dren_o,
  output logic              dwen_o,
  output logic              mem_to_reg_o,
  output logic              lui_o,
  output logic              jal_o,
  output logic              halt_o,
  output logic              hazard_o,
  output logic [31:0]       perf_instr_o,
  output logic [31:0]       perf_stall_o
);
  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23,
                         OP_SW = 6'h2B, OP_HALT = 6'h3F;
  typedef struct packed {
    logic [3:0]        aluop;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wsel;
    logic [WORD_W-1:0] imm_ext;
    logic [25:0]       imm26;
    logic [1:0]        alu_src;
    logic [1:0]        jump_sel;
    logic              branch;
    logic              bne;
    logic              reg_write;
    logic              dren;
    logic              dwen;
    logic              mem_to_reg;
    logic              lui;
    logic              jal;
  } ctrl_t;
  ctrl_t dec, ctrl_d, ctrl_q;
  logic valid_d, valid_q, halted_d, halted_q;
  logic [LOAD_LAT-1:0] sbv_d, sbv_q;
  logic [LOAD_LAT-1:0][REG_AW-1:0] sba_d, sba_q;
  logic [5:0] op, funct;
  logic [15:0] imm;
  logic rt_src, hit, adv, take;
  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign imm   = instr_i[15:0];
  always_comb begin
    dec          = '0;
    dec.aluop    = ALU_ADD;
    dec.rs       = instr_i[25:21];
    dec.rt       = instr_i[20:16];
    dec.wsel     = instr_i[20:16];
    dec.imm_ext  = {{16{imm[15]}}, imm};
    dec.imm26    = instr_i[25:0];
    case (op)
      OP_R: begin
        dec.wsel      = instr_i[15:11];
        dec.reg_write = 1'b1;
        case (funct)
          6'h00: dec.aluop = ALU_SLL;
          6'h02: dec.aluop = ALU_SRL;
          6'h08: begin
            dec.jump_sel  = 2'b10;
            dec.reg_write = 1'b0;
          end
          6'h20, 6'h21: dec.aluop = ALU_ADD;
          6'h22, 6'h23: dec.aluop = ALU_SUB;
          6'h24: dec.aluop = ALU_AND;
          6'h25: dec.aluop = ALU_OR;
          6'h26: dec.aluop = ALU_XOR;
          6'h27: dec.aluop = ALU_NOR;
          6'h2A: dec.aluop = ALU_SLT;
          6'h2B: dec.aluop = ALU_SLTU;
          default: dec.reg_write = 1'b0;
        endcase
      end
      OP_J: dec.jump_sel = 2'b01;
      OP_JAL: begin
        dec.jump_sel  = 2'b01;
        dec.wsel      = REG_AW'(31);
        dec.jal       = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.branch   = 1'b1;
        dec.bne      = op == OP_BNE;
        dec.aluop    = ALU_SUB;
        dec.jump_sel = 2'b11;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec.alu_src   = 2'b10;
        dec.reg_write = 1'b1;
        dec.aluop     = op == OP_SLTI ? ALU_SLT : op == OP_SLTIU ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.alu_src   = 2'b01;
        dec.reg_write = 1'b1;
        dec.imm_ext   = {16'h0, imm};
        dec.aluop     = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_XOR;
      end
      OP_LUI: begin
        dec.lui       = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm_ext   = {imm, 16'h0};
      end
      OP_LW: begin
        dec.alu_src    = 2'b10;
        dec.dren       = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec.alu_src = 2'b10;
        dec.dwen    = 1'b1;
      end
      default: ;
    endcase
  end
  assign rt_src = op == OP_R || op == OP_BEQ || op == OP_BNE || op == OP_SW;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++)
      hit |= sbv_q[i] && sba_q[i] != '0 && (sba_q[i] == dec.rs || (rt_src && sba_q[i] == dec.rt));
  end
  assign hazard_o      = instr_valid_i & ~halted_q & hit;
  assign adv           = ~valid_q | ex_ready_i;
  assign instr_ready_o = adv & instr_valid_i & ~halted_q & (flush_i | ~hazard_o);
  assign take          = instr_ready_o & ~flush_i;
  assign ctrl_d   = adv ? (take ? dec : '0) : ctrl_q;
  assign valid_d  = adv ? take : valid_q;
  assign halted_d = halted_q | (take & op == OP_HALT);
  // Scoreboard only ages when the pipe advances, so a stall keeps the load's distance intact
  always_comb begin
    sbv_d = sbv_q;
    sba_d = sba_q;
    if (adv) begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        sbv_d[i] = sbv_q[i-1];
        sba_d[i] = sba_q[i-1];
      end
      sbv_d[0] = take & dec.dren;
      sba_d[0] = (take & dec.dren) ? dec.wsel : '0;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      sbv_q    <= '0;
      sba_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      sbv_q    <= sbv_d;
      sba_q    <= sba_d;
    end
  end
  assign ctrl_valid_o = valid_q;
  assign halt_o       = halted_q;
  assign aluop_o      = ctrl_q.aluop;
  assign rs_o         = ctrl_q.rs;
  assign rt_o         = ctrl_q.rt;
  assign wsel_o       = ctrl_q.wsel;
  assign imm_ext_o    = ctrl_q.imm_ext;
  assign imm26_o      = ctrl_q.imm26;
  assign alu_src_o    = ctrl_q.alu_src;
  assign jump_sel_o   = ctrl_q.jump_sel;
  assign branch_o     = ctrl_q.branch;
  assign bne_o        = ctrl_q.bne;
  assign reg_write_o  = ctrl_q.reg_write;
  assign dren_o       = ctrl_q.dren;
  assign dwen_o       = ctrl_q.dwen;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign lui_o        = ctrl_q.lui;
  assign jal_o        = ctrl_q.jal;
`ifdef DECODE_CTRL_PERF_EN
  logic [31:0] perf_instr_d, perf_instr_q, perf_stall_d, perf_stall_q;
  assign perf_instr_d = perf_instr_q + 32'(take);
  assign perf_stall_d = perf_stall_q + 32'(hazard_o & ~flush_i & adv);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_stall_q <= perf_stall_d;
    end
  end
  assign perf_instr_o = perf_instr_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_instr_o = '0;
  assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: table-driven decode checks plus hand sequences for stall, flush, hold, reset and halt
module tb_decode_ctrl_pipe;
  logic CLK = 0, nRST = 0;
  logic [31:0] instr = '0, instr2 = '0;
  logic valid = 0, valid2 = 0, flush = 0, ex_ready = 1;
  logic ready, cvalid, branch, bne, rw, dren, dwen, m2r, lui, jal, halt, hazard;
  logic [3:0] aluop;
  logic [4:0] rs, rt, wsel;
  logic [31:0] imm, pi, ps;
  logic [25:0] imm26;
  logic [1:0] src, jsel;
  logic [7:0] flags;
  logic b_ready, b_cvalid, b_branch, b_bne, b_rw, b_dren, b_dwen, b_m2r, b_lui, b_jal, b_halt, b_hazard;
  logic [3:0] b_aluop;
  logic [4:0] b_rs, b_rt, b_wsel;
  logic [31:0] b_imm, b_pi, b_ps;
  logic [25:0] b_imm26;
  logic [1:0] b_src, b_jsel;
  int n_chk = 0, n_fail = 0;
  assign flags = {branch, bne, rw, dren, dwen, m2r, lui, jal};

  decode_ctrl_pipe #(.LOAD_LAT(1)) dut (
    .CLK(CLK), .nRST(nRST), .instr_i(instr), .instr_valid_i(valid), .instr_ready_o(ready),
    .flush_i(flush), .ex_ready_i(ex_ready), .ctrl_valid_o(cvalid), .aluop_o(aluop),
    .rs_o(rs), .rt_o(rt), .wsel_o(wsel), .imm_ext_o(imm), .imm26_o(imm26), .alu_src_o(src),
    .jump_sel_o(jsel), .branch_o(branch), .bne_o(bne), .reg_write_o(rw), .dren_o(dren),
    .dwen_o(dwen), .mem_to_reg_o(m2r), .lui_o(lui), .jal_o(jal), .halt_o(halt),
    .hazard_o(hazard), .perf_instr_o(pi), .perf_stall_o(ps));

  decode_ctrl_pipe #(.LOAD_LAT(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .instr_i(instr2), .instr_valid_i(valid2), .instr_ready_o(b_ready),
    .flush_i(flush), .ex_ready_i(ex_ready), .ctrl_valid_o(b_cvalid), .aluop_o(b_aluop),
    .rs_o(b_rs), .rt_o(b_rt), .wsel_o(b_wsel), .imm_ext_o(b_imm), .imm26_o(b_imm26),
    .alu_src_o(b_src), .jump_sel_o(b_jsel), .branch_o(b_branch), .bne_o(b_bne),
    .reg_write_o(b_rw), .dren_o(b_dren), .dwen_o(b_dwen), .mem_to_reg_o(b_m2r),
    .lui_o(b_lui), .jal_o(b_jal), .halt_o(b_halt), .hazard_o(b_hazard),
    .perf_instr_o(b_pi), .perf_stall_o(b_ps));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  aluop;
    logic [4:0]  wsel;
    logic [31:0] imm;
    logic [1:0]  src;
    logic [1:0]  jsel;
    logic [7:0]  flags;
  } vec_t;
  vec_t v[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // flags = {branch, bne, reg_write, dren, dwen, mem_to_reg, lui, jal}
    v[0]  = '{32'h24058000, 4'd2, 5'd5,  32'hFFFF8000, 2'b10, 2'b00, 8'h20};
    v[1]  = '{32'h34058000, 4'd5, 5'd5,  32'h00008000, 2'b01, 2'b00, 8'h20};
    v[2]  = '{32'h0C000010, 4'd2, 5'd31, 32'h00000010, 2'b00, 2'b01, 8'h21};
    v[3]  = '{32'h00441820, 4'd2, 5'd3,  32'h00001820, 2'b00, 2'b00, 8'h20};
    v[4]  = '{32'h00441822, 4'd3, 5'd3,  32'h00001822, 2'b00, 2'b00, 8'h20};
    v[5]  = '{32'h00041880, 4'd0, 5'd3,  32'h00001880, 2'b00, 2'b00, 8'h20};
    v[6]  = '{32'h00041882, 4'd1, 5'd3,  32'h00001882, 2'b00, 2'b00, 8'h20};
    v[7]  = '{32'h03E00008, 4'd2, 5'd0,  32'h00000008, 2'b00, 2'b10, 8'h00};
    v[8]  = '{32'h1022FFFF, 4'd3, 5'd2,  32'hFFFFFFFF, 2'b00, 2'b11, 8'h80};
    v[9]  = '{32'h1422FFFF, 4'd3, 5'd2,  32'hFFFFFFFF, 2'b00, 2'b11, 8'hC0};
    v[10] = '{32'h8C220000, 4'd2, 5'd2,  32'h00000000, 2'b10, 2'b00, 8'h34};
    v[11] = '{32'hAC220004, 4'd2, 5'd2,  32'h00000004, 2'b10, 2'b00, 8'h08};
    v[12] = '{32'h3C051234, 4'd2, 5'd5,  32'h12340000, 2'b00, 2'b00, 8'h22};
    v[13] = '{32'h0044182A, 4'd8, 5'd3,  32'h0000182A, 2'b00, 2'b00, 8'h20};
    v[14] = '{32'h30058000, 4'd4, 5'd5,  32'h00008000, 2'b01, 2'b00, 8'h20};
    v[15] = '{32'h38058000, 4'd6, 5'd5,  32'h00008000, 2'b01, 2'b00, 8'h20};
    v[16] = '{32'h2C05FFFF, 4'd9, 5'd5,  32'hFFFFFFFF, 2'b10, 2'b00, 8'h20};
    v[17] = '{32'h00441827, 4'd7, 5'd3,  32'h00001827, 2'b00, 2'b00, 8'h20};
    v[18] = '{32'h7C000000, 4'd2, 5'd0,  32'h00000000, 2'b00, 2'b00, 8'h00};
    #2;
    chk("rst_valid", cvalid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_wsel", wsel, 0);
    chk("rst_flags", flags, 0);
    chk("rst_perf_instr", pi, 0);
    chk("rst_perf_stall", ps, 0);
    #10 nRST = 1;
    tick();
    for (int i = 0; i < 19; i++) begin
      instr = v[i].instr;
      valid = 1;
      #1;
      chk($sformatf("vec%0d_ready", i), ready, 1);
      tick();
      valid = 0;
      chk($sformatf("vec%0d_valid", i), cvalid, 1);
      chk($sformatf("vec%0d_aluop", i), aluop, v[i].aluop);
      chk($sformatf("vec%0d_wsel", i), wsel, v[i].wsel);
      chk($sformatf("vec%0d_imm", i), imm, v[i].imm);
      chk($sformatf("vec%0d_alu_src", i), src, v[i].src);
      chk($sformatf("vec%0d_jump_sel", i), jsel, v[i].jsel);
      chk($sformatf("vec%0d_flags", i), flags, v[i].flags);
      tick();
    end
    // asynchronous reset with a loaded register and a live scoreboard entry
    instr = 32'h8C220000;
    valid = 1;
    tick();
    valid = 0;
    chk("mid_pre_valid", cvalid, 1);
    #1 nRST = 0;
    #1;
    chk("mid_rst_valid", cvalid, 0);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_wsel", wsel, 0);
    chk("mid_rst_aluop", aluop, 0);
    #1 nRST = 1;
    instr = 32'h00441820;
    valid = 1;
    #1;
    chk("post_rst_hazard", hazard, 0);
    chk("post_rst_ready", ready, 1);
    tick();
    valid = 0;
    chk("post_rst_valid", cvalid, 1);
    chk("post_rst_wsel", wsel, 3);
    tick();
    // load-use stall, LOAD_LAT=1
    instr = 32'h8C220000;
    valid = 1;
    tick();
    instr = 32'h00441820;
    #1;
    chk("lu_hazard", hazard, 1);
    chk("lu_ready", ready, 0);
    tick();
    chk("lu_bubble", cvalid, 0);
    #1;
    chk("lu_hazard_clear", hazard, 0);
    chk("lu_ready_after", ready, 1);
    tick();
    valid = 0;
    chk("lu_add_valid", cvalid, 1);
    chk("lu_add_wsel", wsel, 3);
    chk("lu_add_aluop", aluop, 2);
    chk("lu_add_rs", rs, 2);
    chk("lu_add_rt", rt, 4);
    tick();
    // flush of a dependent instruction: consumed, no stall
    instr = 32'h8C220000;
    valid = 1;
    tick();
    instr = 32'h00441820;
    flush = 1;
    #1;
    chk("fl_hazard", hazard, 1);
    chk("fl_ready", ready, 1);
    tick();
    flush = 0;
    chk("fl_bubble", cvalid, 0);
`ifdef DECODE_CTRL_PERF_EN
    chk("fl_perf_stall", ps, 1);
    chk("fl_perf_instr", pi, 4);
`else
    chk("fl_perf_stall", ps, 0);
    chk("fl_perf_instr", pi, 0);
`endif
    #1;
    chk("fl_sb_drained", hazard, 0);
    valid = 0;
    tick();
    // load-use stall, LOAD_LAT=2
    instr2 = 32'h8C220000;
    valid2 = 1;
    #1;
    chk("lu2_lw_ready", b_ready, 1);
    tick();
    instr2 = 32'h00441820;
    #1;
    chk("lu2_hazard_c1", b_hazard, 1);
    chk("lu2_ready_c1", b_ready, 0);
    tick();
    chk("lu2_bubble", b_cvalid, 0);
    #1;
    chk("lu2_hazard_c2", b_hazard, 1);
    chk("lu2_ready_c2", b_ready, 0);
    tick();
    #1;
    chk("lu2_hazard_c3", b_hazard, 0);
    chk("lu2_ready_c3", b_ready, 1);
    tick();
    valid2 = 0;
    chk("lu2_add_valid", b_cvalid, 1);
    chk("lu2_add_wsel", b_wsel, 3);
    tick();
    // jal then EX back-pressure for three cycles
    instr = 32'h0C000010;
    valid = 1;
    tick();
    chk("jal_valid", cvalid, 1);
    chk("jal_imm26", imm26, 32'h10);
    chk("jal_jsel", jsel, 1);
    instr = 32'h00441820;
    ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_ready", k), ready, 0);
      chk($sformatf("hold%0d_wsel", k), wsel, 31);
      chk($sformatf("hold%0d_flags", k), flags, 8'h21);
      chk($sformatf("hold%0d_imm26", k), imm26, 32'h10);
      tick();
    end
    ex_ready = 1;
    #1;
    chk("hold_release_ready", ready, 1);
    tick();
    valid = 0;
    chk("hold_next_wsel", wsel, 3);
    chk("hold_next_jal", jal, 0);
    tick();
    // flushed halt leaves the core running
    instr = 32'hFFFFFFFF;
    valid = 1;
    flush = 1;
    #1;
    chk("fhalt_ready", ready, 1);
    tick();
    flush = 0;
    chk("fhalt_halt", halt, 0);
    chk("fhalt_bubble", cvalid, 0);
    instr = 32'h00441820;
    #1;
    chk("fhalt_next_ready", ready, 1);
    valid = 0;
    tick();
    // real halt is sticky until reset
    instr = 32'hFFFFFFFF;
    valid = 1;
    #1;
    chk("halt_ready", ready, 1);
    tick();
    chk("halt_set", halt, 1);
    chk("halt_valid", cvalid, 1);
    chk("halt_flags", flags, 0);
    instr = 32'h00441820;
    #1;
    chk("halt_block_ready", ready, 0);
    tick();
    chk("halt_drain_valid", cvalid, 0);
    chk("halt_drain_halt", halt, 1);
    repeat (3) tick();
    chk("halt_sticky", halt, 1);
    chk("halt_still_blocked", ready, 0);
    chk("halt_no_hazard", hazard, 0);
    nRST = 0;
    #1;
    chk("halt_rst_clear", halt, 0);
    nRST = 1;
    #1;
    chk("halt_rst_ready", ready, 1);
    tick();
    valid = 0;
    chk("halt_rst_accept", cvalid, 1);
    chk("halt_rst_wsel", wsel, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
